// File: rtl/dog_up_sampler.sv
// 2x nearest-neighbour upsampler draining one octave FIFO.
// Even rows stream from the FIFO; odd rows replay the line buffer.
module dog_up_sampler #(
  parameter int IN_WIDTH  = 400,
  parameter int IN_HEIGHT = 300,
  parameter int COL_W     = 9,
  parameter int ROW_W     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       fifo_valid,
  input  logic [7:0] fifo_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eol,
  output logic       frame_done,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    E0,
    E1,
    R0,
    R1
  } state_t;

  localparam int IDX_W =
    (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST =
    ROW_W'(IN_HEIGHT - 1);

  state_t           state;
  state_t           state_nx;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nx;
  logic [ROW_W-1:0] row;
  logic [7:0]       pix;
  logic [7:0]       linebuf [IN_WIDTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             col_end;
  logic             row_end;
  logic             accept;
  logic             rd_req;

  assign col_nx  = col + 1'b1;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);
  assign wr_idx  = col[IDX_W-1:0];
  assign rd_idx  = (state == R1) ?
                   col_nx[IDX_W-1:0] : '0;
  assign accept  = out_valid & out_ready;
  assign out_data = pix;

  // rd_en is masked during reset so the FIFO is never popped
  // for a word the FSM is about to forget.
  assign fifo_rd_en = rd_req & ~rst;

  always_comb begin
    state_nx  = state;
    rd_req    = 1'b0;
    out_valid = 1'b0;
    out_sof   = 1'b0;
    out_eol   = 1'b0;
    unique case (state)
      REQ: begin
        rd_req = ~fifo_empty;
        if (!fifo_empty)
          state_nx = WAIT;
      end
      WAIT: begin
        if (fifo_valid)
          state_nx = E0;
      end
      E0: begin
        out_valid = 1'b1;
        out_sof   = (row == '0) && (col == '0);
        if (out_ready)
          state_nx = E1;
      end
      E1: begin
        out_valid = 1'b1;
        out_eol   = col_end;
        if (out_ready)
          state_nx = col_end ? R0 : REQ;
      end
      R0: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = R1;
      end
      R1: begin
        out_valid = 1'b1;
        out_eol   = col_end;
        if (out_ready)
          state_nx = col_end ? REQ : R0;
      end
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      col        <= '0;
      row        <= '0;
      pix        <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      if (fifo_valid && state != WAIT)
        proto_err <= 1'b1;
      case (state)
        WAIT: begin
          if (fifo_valid)
            pix <= fifo_dout;
        end
        E1: begin
          if (accept) begin
            if (col_end) begin
              col <= '0;
              pix <= linebuf[rd_idx];
            end else begin
              col <= col_nx;
            end
          end
        end
        R1: begin
          if (accept) begin
            if (!col_end) begin
              col <= col_nx;
              pix <= linebuf[rd_idx];
            end else begin
              col <= '0;
              if (row_end) begin
                row        <= '0;
                frame_done <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Plain storage, no reset: contents are rewritten every even row.
  always_ff @(posedge clk) begin
    if (state == WAIT && fifo_valid)
      linebuf[wr_idx] <= fifo_dout;
  end

endmodule

// File: tb/tb_dog_up_sampler.sv
// Scoreboard bench for dog_up_sampler on a 4x2 frame.
// A FIFO model feeds words; expected pixels are queued at load.
module tb_dog_up_sampler;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic       fifo_valid = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;
  logic       frame_done;
  logic       proto_err;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  bit inject = 1'b0;

  always #5 clk = ~clk;

  dog_up_sampler #(
    .IN_WIDTH (W),
    .IN_HEIGHT(H),
    .COL_W    (3),
    .ROW_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_valid(fifo_valid),
    .fifo_dout (fifo_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done),
    .proto_err (proto_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic load_frame(input logic [7:0] base,
                            input bit push_words);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (push_words)
          fifo_q.push_back(base + 8'(r * W + c));
    for (int r = 0; r < H; r++)
      for (int p = 0; p < 2; p++)
        for (int x = 0; x < 2 * W; x++) begin
          e.d    = base + 8'(r * W + x / 2);
          e.sof  = (r == 0 && p == 0 && x == 0);
          e.eol  = (x == 2 * W - 1);
          e.last = (r == H - 1 && p == 1 && x == 2 * W - 1);
          exp_q.push_back(e);
        end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0)
      check("drain_timeout", 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt < target)
      check("acc_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_sof"}, 32'(out_sof), 0);
    check({tag, "_eol"}, 32'(out_eol), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_perr"}, 32'(proto_err), 0);
    check({tag, "_data"}, 32'(out_data), 0);
  endtask

  // FIFO with one-cycle read latency
  always begin : fifo_model
    bit pend;
    bit inj;
    @(negedge clk);
    pend = fifo_rd_en;
    inj = inject;
    inject = 1'b0;
    if (fifo_rd_en) begin
      rd_cnt++;
      check("rd_when_empty", 32'(fifo_empty), 0);
    end
    @(posedge clk); #1;
    fifo_valid = pend | inj;
    if (pend && fifo_q.size() > 0)
      fifo_dout = fifo_q.pop_front();
    else if (inj)
      fifo_dout = 8'hEE;
    fifo_empty = (fifo_q.size() == 0);
  end

  bit         fd_exp = 1'b0;
  bit         stall = 1'b0;
  logic [7:0] hold_d;
  logic       hold_sof;
  logic       hold_eol;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (frame_done || fd_exp)
        check("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done)
        fd_cnt++;
      fd_exp = 1'b0;
      if (stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(hold_d));
        check("hold_sof", 32'(out_sof), 32'(hold_sof));
        check("hold_eol", 32'(out_eol), 32'(hold_eol));
      end
      stall    = out_valid && !out_ready;
      hold_d   = out_data;
      hold_sof = out_sof;
      hold_eol = out_eol;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(out_data), 32'(e.d));
          check("sof", 32'(out_sof), 32'(e.sof));
          check("eol", 32'(out_eol), 32'(e.eol));
          fd_exp = e.last;
        end
      end
    end else begin
      stall  = 1'b0;
      fd_exp = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int  a0;
    int  r0;
    int  f0;
    int  busy;
    bit  held;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // full frame, no backpressure
    out_ready = 1'b1;
    r0 = rd_cnt;
    f0 = fd_cnt;
    load_frame(8'd1, 1'b1);
    drain(400);
    check("stream_rd_pulses", 32'(rd_cnt - r0), 8);
    check("stream_frames", 32'(fd_cnt - f0), 1);

    // FIFO runs dry after two words, mid-row
    a0 = acc_cnt;
    load_frame(8'd9, 1'b0);
    fifo_q.push_back(8'd9);
    fifo_q.push_back(8'd10);
    wait_acc(a0 + 4, 200);
    repeat (3) @(posedge clk);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en || out_valid)
        busy++;
    end
    check("starve_idle", 32'(busy), 0);
    @(posedge clk); #1;
    for (int i = 2; i < W * H; i++)
      fifo_q.push_back(8'd9 + 8'(i));
    drain(400);

    // ready toggling, plus a long stall in R1
    a0 = acc_cnt;
    r0 = rd_cnt;
    f0 = fd_cnt;
    held = 1'b0;
    load_frame(8'd17, 1'b1);
    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
      if (!held && acc_cnt == a0 + 9) begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        held = 1'b1;
      end else begin
        out_ready = ~out_ready;
      end
    end
    out_ready = 1'b1;
    drain(400);
    check("bp_rd_pulses", 32'(rd_cnt - r0), 8);
    check("bp_frames", 32'(fd_cnt - f0), 1);

    // stray fifo_valid while stalled in R0
    a0 = acc_cnt;
    load_frame(8'd25, 1'b1);
    wait_acc(a0 + 8, 400);
    out_ready = 1'b0;
    inject = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("proto_err_set", 32'(proto_err), 1);
    out_ready = 1'b1;
    drain(400);
    check("proto_err_sticky", 32'(proto_err), 1);

    // reset during the second output row
    a0 = acc_cnt;
    load_frame(8'd33, 1'b1);
    wait_acc(a0 + 10, 400);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_mid");
    @(posedge clk); #1;
    fifo_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    f0 = fd_cnt;
    load_frame(8'd1, 1'b1);
    drain(400);
    check("post_rst_frames", 32'(fd_cnt - f0), 1);

    // two frames back to back
    r0 = rd_cnt;
    f0 = fd_cnt;
    load_frame(8'd1, 1'b1);
    load_frame(8'd9, 1'b1);
    drain(800);
    check("b2b_rd_pulses", 32'(rd_cnt - r0), 16);
    check("b2b_frames", 32'(fd_cnt - f0), 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
